// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access controller: RAM modes,
// FSM state encoding, latched request payload and alignment/beat helpers.
package mem_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] BYTE_MODE  = 2'b00;
  localparam logic [1:0] DBYTE_MODE = 2'b01;
  localparam logic [1:0] WORD_MODE  = 2'b10;
  localparam logic [1:0] BAD_MODE   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      BYTE_MODE:  return 1'b1;
      DBYTE_MODE: return ~addr_lo[0];
      WORD_MODE:  return (addr_lo == 2'b00);
      default:    return 1'b0;
    endcase
  endfunction

  // Index of the final beat: aligned accesses are one beat, split ones go byte by byte
  function automatic logic [1:0] last_beat(input logic [1:0] size, input logic [1:0] addr_lo);
    if (is_aligned(size, addr_lo)) return 2'd0;
    else if (size == DBYTE_MODE)   return 2'd1;
    else                           return 2'd3;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Sign/zero extension of an assembled load result according to access size.
module load_ext
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext_c
);

  always_comb begin
    ext_c = data;
    case (size)
      BYTE_MODE:  ext_c = {{24{sign_ext & data[7]}}, data[7:0]};
      DBYTE_MODE: ext_c = {{16{sign_ext & data[15]}}, data[15:0]};
      default:    ext_c = data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side load/store controller: issues aligned accesses in one RAM beat and
// splits misaligned halfword/word accesses into little-endian byte beats.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [1:0]        ram_mode,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [1:0]        k_q, k_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] ext_c;
  logic              aligned;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [1:0]        ram_mode_q, ram_mode_d;
  logic              ram_we_q, ram_we_d;

  assign aligned = is_aligned(req_q.size, req_q.addr[1:0]);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = (size == BAD_MODE) ? DONE : ACCESS;
      end
      ACCESS: begin
        if (k_q == last_beat(req_q.size, req_q.addr[1:0])) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter and load byte assembly
  always_comb begin
    req_d = req_q;
    k_d   = k_q;
    asm_d = asm_q;
    if (state_q == IDLE && req) begin
      req_d.we       = we;
      req_d.size     = size;
      req_d.sign_ext = sign_ext;
      req_d.addr     = addr;
      req_d.wdata    = wdata;
      k_d            = 2'd0;
      asm_d          = '0;
    end else if (state_q == ACCESS) begin
      k_d = k_q + 2'd1;
      if (aligned) asm_d = ram_dout;
      else         asm_d[{k_q, 3'b000} +: 8] = ram_dout[7:0];
    end
  end

  load_ext u_load_ext (
    .data     (asm_d),
    .size     (req_q.size),
    .sign_ext (req_q.sign_ext),
    .ext_c    (ext_c)
  );

  // Registered outputs; RAM drive is precomputed for the beat about to be active
  always_comb begin
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    err_d      = (state_q == IDLE) && (state_d == DONE);
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_mode_d = ram_mode_q;
    ram_we_d   = 1'b0;
    if (state_q == ACCESS && state_d == DONE && !req_q.we) rdata_d = ext_c;
    if (state_d == ACCESS) begin
      if (is_aligned(req_d.size, req_d.addr[1:0])) begin
        ram_addr_d = req_d.addr;
        ram_mode_d = req_d.size;
        ram_din_d  = req_d.wdata;
      end else begin
        ram_addr_d = req_d.addr + ADDR_W'(k_d);
        ram_mode_d = BYTE_MODE;
        ram_din_d  = {24'b0, req_d.wdata[{k_d, 3'b000} +: 8]};
      end
      ram_we_d = req_d.we;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      req_q      <= '0;
      k_q        <= 2'd0;
      asm_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_mode_q <= BYTE_MODE;
      ram_we_q   <= 1'b0;
    end else begin
      req_q      <= req_d;
      k_q        <= k_d;
      asm_q      <= asm_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_mode_q <= ram_mode_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_mode = ram_mode_q;
  assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a byte-addressed behavioural RAM.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [1:0]  ram_mode;
  logic        ram_we;
  logic [31:0] ram_dout;

  mem_access_ctrl dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_mode (ram_mode),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Behavioural RAM: little-endian bytes, combinational read, write on clock edge
  logic [7:0]  mem [4096];
  logic [19:0] wr_log [$];
  int          wr_cnt = 0;

  always_comb begin
    case (ram_mode)
      2'b00:   ram_dout = {24'b0, mem[ram_addr]};
      2'b01:   ram_dout = {16'b0, mem[ram_addr + 12'd1], mem[ram_addr]};
      default: ram_dout = {mem[ram_addr + 12'd3], mem[ram_addr + 12'd2],
                           mem[ram_addr + 12'd1], mem[ram_addr]};
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      wr_cnt <= wr_cnt + 1;
      mem[ram_addr] <= ram_din[7:0];
      if (ram_mode == 2'b00) wr_log.push_back({ram_addr, ram_din[7:0]});
      if (ram_mode != 2'b00) mem[ram_addr + 12'd1] <= ram_din[15:8];
      if (ram_mode == 2'b10) begin
        mem[ram_addr + 12'd2] <= ram_din[23:16];
        mem[ram_addr + 12'd3] <= ram_din[31:24];
      end
    end
  end

  typedef struct {
    string       tag;
    int          done_cyc;
    logic        err;
    logic [31:0] rdata;
    int          mode;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] last_rd = 32'h0;

  // Scoreboard: every done pulse is matched against the oldest outstanding request
  always @(negedge clk) begin
    if (!clr && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check({x.tag, "_latency"}, 32'(cyc), 32'(x.done_cyc));
        check({x.tag, "_err"}, {31'b0, err}, {31'b0, x.err});
        check({x.tag, "_rdata"}, rdata, x.rdata);
        check({x.tag, "_ram_we"}, {31'b0, ram_we}, 32'd0);
        if (x.mode >= 0) check({x.tag, "_mode"}, {30'b0, ram_mode}, 32'(x.mode));
      end
    end
  end

  function automatic exp_t mk_exp(input string tag, input int dc, input logic w,
                                  input logic e, input logic [31:0] rd, input int md);
    exp_t x;
    x.tag      = tag;
    x.done_cyc = dc;
    x.err      = e;
    x.rdata    = (w || e) ? last_rd : rd;
    x.mode     = md;
    return x;
  endfunction

  task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [11:0] a, input logic [31:0] wd, input int lat,
                       input logic [31:0] exp_rd, input int md);
    logic e;
    @(negedge clk);
    e = (sz == 2'b11);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    exp_q.push_back(mk_exp(tag, cyc + lat, w, e, exp_rd, md));
    if (!w && !e) last_rd = exp_rd;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      @(negedge clk);
    end
    check("timeout_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                     input logic [11:0] a, input logic [31:0] wd, input int lat,
                     input logic [31:0] exp_rd, input int md);
    issue(tag, w, sz, sx, a, wd, lat, exp_rd, md);
    wait_idle();
  endtask

  initial begin
    int          base;
    int          wc;
    logic [19:0] exp_wr [4];
    logic [7:0]  old3, old4;

    clr = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 12'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_done",     {31'b0, done},     32'd0);
    check("rst_err",      {31'b0, err},      32'd0);
    check("rst_ram_we",   {31'b0, ram_we},   32'd0);
    check("rst_rdata",    rdata,             32'd0);
    check("rst_ram_addr", {20'b0, ram_addr}, 32'd0);
    check("rst_ram_din",  ram_din,           32'd0);
    check("rst_ram_mode", {30'b0, ram_mode}, 32'd0);
    clr = 1'b0;

    run("st_w_al",   1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 2, 32'h0,        2);
    run("ld_w_al",   1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        2, 32'hDEADBEEF, 2);
    run("st_w_pre",  1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF0000, 2, 32'h0,        2);
    run("ld_b_sx",   1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        2, 32'hFFFFFF80, 0);
    run("ld_b_zx",   1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        2, 32'h00000080, 0);

    base = wr_log.size();
    run("st_w_wrap", 1'b1, 2'b10, 1'b0, 12'hFFF, 32'h11223344, 5, 32'h0,        0);
    check("wrap_nwrites", 32'(wr_log.size() - base), 32'd4);
    exp_wr[0] = 20'hFFF44; exp_wr[1] = 20'h00033; exp_wr[2] = 20'h00122; exp_wr[3] = 20'h00211;
    for (int i = 0; i < 4; i++)
      if (base + i < wr_log.size()) check("wrap_write", {12'b0, wr_log[base + i]}, {12'b0, exp_wr[i]});
    run("ld_w_wrap", 1'b0, 2'b10, 1'b0, 12'hFFF, 32'h0,        5, 32'h11223344, 0);

    run("st_h_mis",  1'b1, 2'b01, 1'b0, 12'h021, 32'h0000ABCD, 3, 32'h0,        0);
    run("ld_h_sx",   1'b0, 2'b01, 1'b1, 12'h021, 32'h0,        3, 32'hFFFFABCD, 0);
    run("ld_h_zx",   1'b0, 2'b01, 1'b0, 12'h021, 32'h0,        3, 32'h0000ABCD, 0);
    run("st_h_al",   1'b1, 2'b01, 1'b0, 12'h040, 32'h00008001, 2, 32'h0,        1);
    run("ld_h_al",   1'b0, 2'b01, 1'b1, 12'h040, 32'h0,        2, 32'hFFFF8001, 1);

    wc = wr_cnt;
    run("bad_size",  1'b1, 2'b11, 1'b0, 12'h050, 32'hCAFEF00D, 1, 32'h0,       -1);
    check("bad_size_no_write", 32'(wr_cnt), 32'(wc));

    // req held high: ignored through ACCESS/DONE, accepted again in the next IDLE
    @(negedge clk);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 12'h010; req = 1'b1;
    exp_q.push_back(mk_exp("held_1", cyc + 2, 1'b0, 1'b0, 32'h80FF0000, 2));
    exp_q.push_back(mk_exp("held_2", cyc + 5, 1'b0, 1'b0, 32'h80FF0000, 2));
    last_rd = 32'h80FF0000;
    repeat (4) @(posedge clk);
    #1 req = 1'b0;
    wait_idle();

    // reset during beat 2 of a misaligned word store
    old3 = mem[12'h103];
    old4 = mem[12'h104];
    @(negedge clk);
    we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 12'h101; wdata = 32'h55667788; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("abort_busy",   {31'b0, busy},   32'd0);
    check("abort_ram_we", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    last_rd = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, done}, 32'd0);
    end
    check("abort_byte0", {24'b0, mem[12'h101]}, 32'h88);
    check("abort_byte1", {24'b0, mem[12'h102]}, 32'h77);
    check("abort_byte2", {24'b0, mem[12'h103]}, {24'b0, old3});
    check("abort_byte3", {24'b0, mem[12'h104]}, {24'b0, old4});

    run("ld_after_abort", 1'b0, 2'b10, 1'b0, 12'hFFF, 32'h0, 5, 32'h11223344, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
